// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             co;
  logic             ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_PIPE_SAT_EN to clamp the result to signed saturation on overflow.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input logic              clk,
  input logic              rst,
  cla_pipe_adder_if.slave  bus
);
  localparam int NG = int'(WIDTH / 4);

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end
  if (GROUP != 4) begin : g_bad_group
    $error("cla_pipe_adder: GROUP must be 4");
  end

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] p_q, p_d, g_q, g_d;
  logic [NG-1:0]    gg_q, gg_d, gp_q, gp_d;
  logic             c0_q, c0_d;

  // Stage 2 state
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             s2_adv, s1_adv, accept;
  logic [WIDTH-1:0] b_eff;
  logic [NG:0]      cg;
  logic [WIDTH-1:0] cb;
  logic [WIDTH-1:0] sum_raw;
  logic             co_raw, ovf_raw;

  always_comb begin
    s2_adv = !out_valid_q || bus.out_ready;
    s1_adv = !s1_valid_q || s2_adv;
    accept = bus.in_valid && s1_adv;
  end

  always_comb begin
    b_eff      = bus.sub ? ~bus.b : bus.b;
    s1_valid_d = s1_valid_q;
    p_d        = p_q;
    g_d        = g_q;
    gg_d       = gg_q;
    gp_d       = gp_q;
    c0_d       = c0_q;
    if (s1_adv) begin
      s1_valid_d = bus.in_valid;
    end
    if (accept) begin
      p_d  = bus.a ^ b_eff;
      g_d  = bus.a & b_eff;
      c0_d = bus.sub | bus.ci;
      for (int k = 0; k < NG; k++) begin
        gp_d[k] = &p_d[4*k +: 4];
        gg_d[k] = g_d[4*k+3]
                | (p_d[4*k+3] & g_d[4*k+2])
                | (&p_d[4*k+2 +: 2] & g_d[4*k+1])
                | (&p_d[4*k+1 +: 3] & g_d[4*k]);
      end
    end
  end

  // Carries are written as flattened sum-of-products so no term ripples across groups.
  always_comb begin
    logic acc;
    logic term;
    acc   = 1'b0;
    term  = 1'b0;
    cg    = '0;
    cb    = '0;
    cg[0] = c0_q;
    for (int k = 1; k <= NG; k++) begin
      acc = c0_q;
      for (int m = 0; m < k; m++) acc = acc & gp_q[m];
      for (int j = 0; j < k; j++) begin
        term = gg_q[j];
        for (int m = j + 1; m < k; m++) term = term & gp_q[m];
        acc = acc | term;
      end
      cg[k] = acc;
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < 4; i++) begin
        acc = cg[k];
        for (int m = 0; m < i; m++) acc = acc & p_q[4*k+m];
        for (int j = 0; j < i; j++) begin
          term = g_q[4*k+j];
          for (int m = j + 1; m < i; m++) term = term & p_q[4*k+m];
          acc = acc | term;
        end
        cb[4*k+i] = acc;
      end
    end
    sum_raw = p_q ^ cb;
    co_raw  = cg[NG];
    ovf_raw = cb[WIDTH-1] ^ cg[NG];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    co_d        = co_q;
    ovf_d       = ovf_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d = sum_raw;
        co_d  = co_raw;
        ovf_d = ovf_raw;
`ifdef CLA_PIPE_SAT_EN
        // Both operand MSBs equal on overflow, so g at the MSB tells the direction.
        if (ovf_raw) begin
          sum_d = g_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      p_q         <= '0;
      g_q         <= '0;
      gg_q        <= '0;
      gp_q        <= '0;
      c0_q        <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      p_q         <= p_d;
      g_q         <= g_d;
      gg_q        <= gg_d;
      gp_q        <= gp_d;
      c0_q        <= c0_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      co_q        <= co_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder: directed corner cases, stall/reset scenarios, random stream.
module tb_cla_pipe_adder;
  localparam int W = 16;
  typedef logic [W+1:0] exp_t;  // {ovf, co, sum}

  localparam logic signed [W+1:0] SMAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] SMIN = {3'b111, {(W-1){1'b0}}};
`ifdef CLA_PIPE_SAT_EN
  localparam logic [W-1:0] E3B_SUM = 16'h8000;
  localparam logic [W-1:0] E4_SUM  = 16'h7FFF;
`else
  localparam logic [W-1:0] E3B_SUM = 16'h7FFF;
  localparam logic [W-1:0] E4_SUM  = 16'h8000;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(W))  bus ();
  cla_pipe_adder_if #(.WIDTH(64)) bus64 ();

  cla_pipe_adder #(.WIDTH(W), .GROUP(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cla_pipe_adder #(.WIDTH(64), .GROUP(4)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed/unsigned interpretations.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    logic [W-1:0]          bb;
    logic                  c0;
    logic [W:0]            full;
    logic signed [W+1:0]   s;
    logic                  ovf;
    logic [W-1:0]          r;
    bb   = sub ? ~b : b;
    c0   = sub ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    s    = $signed({{2{a[W-1]}}, a}) + $signed({{2{bb[W-1]}}, bb})
         + $signed({{(W+1){1'b0}}, c0});
    ovf  = (s > SMAX) || (s < SMIN);
    r    = full[W-1:0];
`ifdef CLA_PIPE_SAT_EN
    if (ovf) r = (s > 0) ? SMAX[W-1:0] : SMIN[W-1:0];
`endif
    return {ovf, full[W], r};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sub, input exp_t exp);
    bus.a        = a;
    bus.b        = b;
    bus.ci       = ci;
    bus.sub      = sub;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(exp);
        @(posedge clk);
        #1;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_errors++;
    $display("FAIL accept_timeout: got in_ready=0 for 64 cycles expected accept");
  endtask

  task automatic directed(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sub, input exp_t exp);
    send(a, b, ci, sub, exp);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("latency_cycle1", 72'(bus.out_valid), 72'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("latency_cycle2", 72'(bus.out_valid), 72'(1));
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every consumed result and checks hold-stability under stall.
  initial begin : monitor
    logic prev_stall;
    exp_t prev_val;
    prev_stall = 1'b0;
    prev_val   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold", 72'({bus.out_valid, bus.ovf, bus.co, bus.sum}),
              72'({1'b1, prev_val}));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_result: got %0h expected no result",
                     {bus.ovf, bus.co, bus.sum});
          end else begin
            chk("result", 72'({bus.ovf, bus.co, bus.sum}), 72'(sb.pop_front()));
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_val   = {bus.ovf, bus.co, bus.sum};
      end
    end
  end

  initial begin : rand_ready_drv
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [W-1:0] ra, rb;
    logic         rci, rsub;
    logic [W-1:0] edge_vals [4];
    bit           seen;
    edge_vals[0] = 16'h0000;
    edge_vals[1] = 16'hFFFF;
    edge_vals[2] = 16'h7FFF;
    edge_vals[3] = 16'h8000;

    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.ci          = 1'b0;
    bus.sub         = 1'b0;
    bus.out_ready   = 1'b1;
    bus64.in_valid  = 1'b0;
    bus64.a         = '0;
    bus64.b         = '0;
    bus64.ci        = 1'b0;
    bus64.sub       = 1'b0;
    bus64.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 72'({bus.out_valid, bus.sum, bus.co, bus.ovf, bus.in_ready}),
        72'({1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}));
    @(posedge clk);
    #1;

    directed(16'h1234, 16'h0FCD, 1'b1, 1'b0, {2'b00, 16'h2202});
    directed(16'hFFFF, 16'h0000, 1'b1, 1'b0, {2'b01, 16'h0000});
    directed(16'h0005, 16'h0007, 1'b1, 1'b1, {2'b00, 16'hFFFE});
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, E3B_SUM});
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b10, E4_SUM});

    // 64-bit carry through all sixteen groups
    bus64.a        = '1;
    bus64.b        = '0;
    bus64.ci       = 1'b1;
    bus64.in_valid = 1'b1;
    @(negedge clk);
    chk("w64_in_ready", 72'(bus64.in_ready), 72'(1));
    @(posedge clk);
    #1;
    bus64.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("w64_result", 72'({bus64.out_valid, bus64.ovf, bus64.co, bus64.sum}),
        72'({1'b1, 1'b0, 1'b1, 64'h0}));
    @(posedge clk);
    #1;

    // Five back-to-back beats with a 3-cycle output stall
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          ra   = W'($urandom);
          rb   = W'($urandom);
          rsub = 1'(i % 2);
          send(ra, rb, 1'b1, rsub, model(ra, rb, 1'b1, rsub));
        end
        bus.in_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
          @(negedge clk);
          seen = bus.out_valid;
        end
        chk("stream_first_valid", 72'(seen), 72'(1));
        chk("stall_in_ready", 72'(bus.in_ready), 72'(0));
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("throughput", 72'(bus.out_valid), 72'(1));
        end
        @(negedge clk);
        chk("no_duplicate", 72'(bus.out_valid), 72'(0));
      end
    join
    @(posedge clk);
    #1;

    // Reset with both stages full and output stalled
    bus.out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0, {2'b00, 16'h3333});
    send(16'h4444, 16'h0001, 1'b0, 1'b1, {2'b00, 16'h4443});
    bus.a = 16'hAAAA;
    rst   = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_state", 72'({bus.out_valid, bus.sum, bus.co, bus.ovf, bus.in_ready}),
        72'({1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale", 72'(bus.out_valid), 72'(0));
    end
    @(posedge clk);
    #1;

    // Randomised stream with random backpressure and input gaps
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rci  = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ra = edge_vals[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) rb = edge_vals[$urandom_range(0, 3)];
      send(ra, rb, rci, rsub, model(ra, rb, rci, rsub));
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    rand_ready   = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", 72'(sb.size()), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
